maq_ajuste: RTL
===============

MAQ_AJUSTE -- requirements
Module: maq_ajuste

Interface
REQ-001 SHALL have port maqa_clock, input, 1 bit: single system clock, all state updates on its rising edge.
REQ-002 SHALL have port maqa_reset, input, 1 bit: reset, synchronous, active-low (0 = reset).
REQ-003 SHALL have port maqa_tick_1hz, input, 1 bit: one-cycle pulse, once per second.
REQ-004 SHALL have port maqa_botao_modo, input, 1 bit: asynchronous mode button level, 1 = pressed.
REQ-005 SHALL have port maqa_botao_inc, input, 1 bit: asynchronous increment button level, 1 = pressed.
REQ-006 SHALL have port maqa_incrementa_hora_in, input, 1 bit: minutes-counter carry (1 while minutes = 59).
REQ-007 SHALL have port maqa_min_enable, output, 1 bit: enable for the minutes counter.
REQ-008 SHALL have port maqa_min_incremento, output, 1 bit: one-cycle increment pulse for the minutes counter.
REQ-009 SHALL have port maqa_hora_enable, output, 1 bit: enable for the hours counter.
REQ-010 SHALL have port maqa_hora_incremento, output, 1 bit: one-cycle increment pulse for the hours counter.
REQ-011 SHALL have port maqa_seg_lsd, output, 4 bits: seconds units digit, 0..9.
REQ-012 SHALL have port maqa_seg_msd, output, 3 bits: seconds tens digit, 0..5.
REQ-013 SHALL have port maqa_modo, output, 2 bits: 00 NORMAL, 01 AJUSTE_HORA, 10 AJUSTE_MIN; 11 never driven.
REQ-014 SHALL have port maqa_pisca, output, 1 bit: display blink flag.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer, then detect rising edges against a registered copy of the synchronized level.
REQ-016 SHALL act on a button sampled high at edge N by updating the registered outputs at edge N+2 (2-edge latency).
REQ-017 SHALL advance the FSM on a modo edge: NORMAL -> AJUSTE_HORA -> AJUSTE_MIN -> NORMAL.
REQ-018 SHALL, in NORMAL on each tick, count seconds 00..59 (lsd 9 -> 0 with msd +1; 59 -> 00).
REQ-019 SHALL, on the tick that wraps seconds 59 -> 00, assert maqa_min_incremento for exactly one cycle, registered on the same edge as the wrap.
REQ-020 SHALL, on that same edge, assert maqa_hora_incremento for one cycle only if maqa_incrementa_hora_in = 1 at that edge.
REQ-021 SHALL, in AJUSTE_HORA, produce a one-cycle maqa_hora_incremento per inc edge and never a maqa_min_incremento.
REQ-022 SHALL, in AJUSTE_MIN, produce a one-cycle maqa_min_incremento per inc edge and never a maqa_hora_incremento, so minute wrap does not carry.
REQ-023 SHALL, while inc is held (synchronized level = 1) in an adjust mode, count ticks and, once 2 ticks have elapsed, emit one increment per subsequent tick until release; release clears the repeat count.
REQ-024 SHALL drive maqa_min_enable = 1 in NORMAL and AJUSTE_MIN, else 0; maqa_hora_enable = 1 in NORMAL and AJUSTE_HORA, else 0.
REQ-025 SHALL clear the seconds to 00 on entering AJUSTE_HORA and hold them at 00 through both adjust modes.
REQ-026 SHALL resume counting in NORMAL from 00 at the first tick after the transition edge.
REQ-027 SHALL drive maqa_pisca as follows: 0 in NORMAL; set to 1 on entering either adjust mode; toggled on each tick while in an adjust mode.
REQ-028 SHALL resolve simultaneous events this way:
- modo edge and inc edge in the same cycle: mode change taken, increment discarded.
- modo edge and tick in the same cycle: mode change taken, tick ignored (no seconds count, no toggle).
REQ-029 SHALL ignore the inc button in NORMAL.
REQ-030 SHALL register every increment output high for at most one consecutive cycle per event.

Reset
REQ-031 SHALL, when maqa_reset = 0 at an edge, set mode NORMAL, seconds 00, pisca 0, both increment outputs 0, synchronizers, edge registers and repeat count 0; enables then read 1/1.
REQ-032 SHALL let reset override every other input, including mid-adjust or mid-repeat.
REQ-033 SHALL treat a button held through reset release as a new press: its action appears at the 2nd edge after release.

Verification
REQ-034 SHALL cover seconds wrap: NORMAL at 58, two ticks, carry input 0 -> seconds 59 then 00; min_incremento 1 for one cycle; hora_incremento 0.
REQ-035 SHALL cover hour carry: at 59 with maqa_incrementa_hora_in = 1, one tick -> min_incremento and hora_incremento both 1 on the same single cycle.
REQ-036 SHALL cover the mode cycle: three modo presses -> modo 01, 10, 00, each at N+2 after the press; seconds 00 after the first press; pisca 1 on entering 01.
REQ-037 SHALL cover auto-repeat: AJUSTE_MIN, inc held for 5 ticks -> 1 pulse at press+2 edges, then pulses on ticks 3, 4 and 5 only (4 total).
REQ-038 SHALL cover the collision: modo edge and inc edge in the same cycle in AJUSTE_HORA -> modo 10, hora_incremento stays 0.
REQ-039 SHALL cover reset mid-adjust: in AJUSTE_MIN with pisca 1, maqa_reset = 0 for one edge -> modo 00, seconds 00, pisca 0, enables 1/1.

Source files
------------

// File: rtl/maq_ajuste.sv
// Clock adjust controller: button synchronizers, NORMAL/AJUSTE_HORA/AJUSTE_MIN mode FSM,
// seconds counter, increment pulses with hold-to-repeat and display blink flag.
module maq_ajuste (
    input  logic       maqa_clock,
    input  logic       maqa_reset,
    input  logic       maqa_tick_1hz,
    input  logic       maqa_botao_modo,
    input  logic       maqa_botao_inc,
    input  logic       maqa_incrementa_hora_in,
    output logic       maqa_min_enable,
    output logic       maqa_min_incremento,
    output logic       maqa_hora_enable,
    output logic       maqa_hora_incremento,
    output logic [3:0] maqa_seg_lsd,
    output logic [2:0] maqa_seg_msd,
    output logic [1:0] maqa_modo,
    output logic       maqa_pisca
);

    typedef enum logic [1:0] {
        StNormal     = 2'b00,
        StAjusteHora = 2'b01,
        StAjusteMin  = 2'b10
    } state_t;

    localparam logic [1:0] RepeatStart = 2'd2;

    state_t     state_q, state_d;

    logic       modo_meta_q, modo_sync_q, modo_prev_q;
    logic       inc_meta_q, inc_sync_q, inc_prev_q;
    logic       modo_edge, inc_edge;

    logic [1:0] rep_q, rep_d;
    logic       rep_fire;
    logic       in_adjust;
    logic       tick_eff;
    logic       inc_event;

    logic [3:0] sec_lsd_q, sec_lsd_d;
    logic [2:0] sec_msd_q, sec_msd_d;
    logic       sec_wrap;

    logic       min_inc_q, min_inc_d;
    logic       hora_inc_q, hora_inc_d;
    logic       pisca_q, pisca_d;

    // Two-flop synchronizers plus a registered copy for rising-edge detection.
    always_ff @(posedge maqa_clock) begin
        if (!maqa_reset) begin
            modo_meta_q <= 1'b0;
            modo_sync_q <= 1'b0;
            modo_prev_q <= 1'b0;
            inc_meta_q  <= 1'b0;
            inc_sync_q  <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            modo_meta_q <= maqa_botao_modo;
            modo_sync_q <= modo_meta_q;
            modo_prev_q <= modo_sync_q;
            inc_meta_q  <= maqa_botao_inc;
            inc_sync_q  <= inc_meta_q;
            inc_prev_q  <= inc_sync_q;
        end
    end

    assign modo_edge = modo_sync_q & ~modo_prev_q;
    assign inc_edge  = inc_sync_q & ~inc_prev_q;

    // A mode change swallows any tick or increment seen in the same cycle.
    assign tick_eff  = maqa_tick_1hz & ~modo_edge;
    assign in_adjust = (state_q == StAjusteHora) || (state_q == StAjusteMin);

    // FSM: state register
    always_ff @(posedge maqa_clock) begin
        if (!maqa_reset) begin
            state_q <= StNormal;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (modo_edge) begin
            unique case (state_q)
                StNormal:     state_d = StAjusteHora;
                StAjusteHora: state_d = StAjusteMin;
                StAjusteMin:  state_d = StNormal;
                default:      state_d = StNormal;
            endcase
        end
    end

    // FSM: outputs decoded from the current mode
    always_comb begin
        maqa_modo        = state_q;
        maqa_min_enable  = 1'b0;
        maqa_hora_enable = 1'b0;
        unique case (state_q)
            StNormal: begin
                maqa_min_enable  = 1'b1;
                maqa_hora_enable = 1'b1;
            end
            StAjusteHora: maqa_hora_enable = 1'b1;
            StAjusteMin:  maqa_min_enable  = 1'b1;
            default: begin
                maqa_min_enable  = 1'b0;
                maqa_hora_enable = 1'b0;
            end
        endcase
    end

    // Hold-to-repeat: ticks are counted while inc is held; from the third one on, each fires.
    always_comb begin
        rep_d = rep_q;
        if (!in_adjust || !inc_sync_q || modo_edge) begin
            rep_d = 2'd0;
        end else if (maqa_tick_1hz && (rep_q != RepeatStart)) begin
            rep_d = rep_q + 2'd1;
        end
    end

    assign rep_fire  = inc_sync_q & maqa_tick_1hz & (rep_q == RepeatStart);
    assign inc_event = in_adjust & ~modo_edge & (inc_edge | rep_fire);

    always_comb begin
        sec_lsd_d = sec_lsd_q;
        sec_msd_d = sec_msd_q;
        sec_wrap  = 1'b0;
        if (state_d != StNormal) begin
            sec_lsd_d = 4'd0;
            sec_msd_d = 3'd0;
        end else if ((state_q == StNormal) && tick_eff) begin
            if (sec_lsd_q == 4'd9) begin
                sec_lsd_d = 4'd0;
                if (sec_msd_q == 3'd5) begin
                    sec_msd_d = 3'd0;
                    sec_wrap  = 1'b1;
                end else begin
                    sec_msd_d = sec_msd_q + 3'd1;
                end
            end else begin
                sec_lsd_d = sec_lsd_q + 4'd1;
            end
        end
    end

    always_comb begin
        min_inc_d  = sec_wrap | ((state_q == StAjusteMin) & inc_event);
        hora_inc_d = (sec_wrap & maqa_incrementa_hora_in) |
                     ((state_q == StAjusteHora) & inc_event);
    end

    always_comb begin
        pisca_d = pisca_q;
        if (state_d == StNormal) begin
            pisca_d = 1'b0;
        end else if (state_d != state_q) begin
            pisca_d = 1'b1;
        end else if (maqa_tick_1hz) begin
            pisca_d = ~pisca_q;
        end
    end

    always_ff @(posedge maqa_clock) begin
        if (!maqa_reset) begin
            rep_q      <= 2'd0;
            sec_lsd_q  <= 4'd0;
            sec_msd_q  <= 3'd0;
            min_inc_q  <= 1'b0;
            hora_inc_q <= 1'b0;
            pisca_q    <= 1'b0;
        end else begin
            rep_q      <= rep_d;
            sec_lsd_q  <= sec_lsd_d;
            sec_msd_q  <= sec_msd_d;
            min_inc_q  <= min_inc_d;
            hora_inc_q <= hora_inc_d;
            pisca_q    <= pisca_d;
        end
    end

    assign maqa_seg_lsd         = sec_lsd_q;
    assign maqa_seg_msd         = sec_msd_q;
    assign maqa_min_incremento  = min_inc_q;
    assign maqa_hora_incremento = hora_inc_q;
    assign maqa_pisca           = pisca_q;

endmodule
